// File: rtl/pm_irq_pkg.sv
// Shared types, sizes and default bus addresses for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pm_irq_pkg;

    localparam int NUM_IRQ = 32;
    localparam int NUM_GRP = 8;
    localparam int GRP_SIZE = NUM_IRQ / NUM_GRP;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;
    typedef logic [1:0] irq_pri_t;

    localparam logic [23:0] IRQ_PRI_DEF = 24'h2020;
    localparam logic [23:0] IRQ_ENA_DEF = 24'h2023;
    localparam logic [23:0] IRQ_ACT_DEF = 24'h2027;
    localparam logic [23:0] IRQ_SWT_DEF = 24'h202B;

    // Priority of the group that source n belongs to.
    function automatic irq_pri_t grp_pri(input logic [2*NUM_GRP-1:0] pri, input int n);
        return pri[2*(n/GRP_SIZE) +: 2];
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Picks the highest-priority pending source; ties resolve to the lowest index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
//   req_vec  in  32  act & ena
//   grp_pri  in  16  2-bit priority per group of four sources
//   valid/index/pri  out  winner present, its source index and priority
module irq_priority_encoder
    import pm_irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0]   req_vec,
    input  logic [2*NUM_GRP-1:0] grp_pri_in,
    output logic                 valid,
    output logic [4:0]           index,
    output irq_pri_t             pri
);

    irq_pri_t best;
    irq_pri_t p;

    // Scanning upward with a strict '>' keeps the lowest index on ties.
    // A group priority of 0 can never beat best=0, so it masks the group.
    always_comb begin
        best  = '0;
        p     = '0;
        valid = 1'b0;
        index = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            p = grp_pri(grp_pri_in, n);
            if (req_vec[n] && (p > best)) begin
                best  = p;
                index = 5'(n);
                valid = 1'b1;
            end
        end
        pri = best;
    end

endmodule

// File: rtl/irq_controller.sv
// Latches source pulses into active flags and presents the best enabled one to the CPU.
// Latency: src pulse at N -> act at N+1 -> irq_req/vector/pri registered at N+2.
// Backpressure: one request outstanding; irq_ack moves it to service, others stay pending.
//   Ports: clk, reset (sync, active-high), clk_ce; 24-bit CPU bus (bus_write, bus_read,
//   bus_address_in, bus_data_in, bus_data_out); irq_src[31:0]; irq_req/irq_vector/irq_pri; irq_ack.
//   Optional feature macro: IRQ_SWTRIG_EN (software trigger register at IRQ_SWT).
module irq_controller
    import pm_irq_pkg::*;
#(
    parameter logic [23:0] IRQ_PRI = IRQ_PRI_DEF,
    parameter logic [23:0] IRQ_ENA = IRQ_ENA_DEF,
    parameter logic [23:0] IRQ_ACT = IRQ_ACT_DEF,
    parameter logic [23:0] IRQ_SWT = IRQ_SWT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_ce,
    input  logic               bus_write,
    input  logic               bus_read,
    input  logic [23:0]        bus_address_in,
    input  logic [7:0]         bus_data_in,
    output logic [7:0]         bus_data_out,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               irq_req,
    output logic [4:0]         irq_vector,
    output irq_pri_t           irq_pri,
    input  logic               irq_ack
);

    logic [2*NUM_GRP-1:0] pri_q, pri_d;
    logic [NUM_IRQ-1:0]   ena_q, ena_d;
    logic [NUM_IRQ-1:0]   act_q, act_set, act_clr;
    logic [NUM_IRQ-1:0]   cand;
    logic [7:0]           rd_dat;

    logic                 win_vld;
    logic [4:0]           win_idx;
    irq_pri_t             win_pri;

    irq_state_t           state_q, state_d;
    logic [4:0]           vec_q, vec_d;
    irq_pri_t             prio_q, prio_d;
    logic                 req_q;

    // ---------------- register write decode ----------------
    always_comb begin
        pri_d   = pri_q;
        ena_d   = ena_q;
        act_clr = '0;
        act_set = irq_src;
        if (bus_write) begin
            for (int k = 0; k < 2; k++) begin
                if (bus_address_in == IRQ_PRI + 24'(k))
                    pri_d[8*k +: 8] = bus_data_in;
            end
            for (int k = 0; k < 4; k++) begin
                if (bus_address_in == IRQ_ENA + 24'(k))
                    ena_d[8*k +: 8] = bus_data_in;
                if (bus_address_in == IRQ_ACT + 24'(k))
                    act_clr[8*k +: 8] = bus_data_in;
            end
`ifdef IRQ_SWTRIG_EN
            if ((bus_address_in == IRQ_SWT) && bus_data_in[7])
                act_set[bus_data_in[4:0]] = 1'b1;
`endif
        end
    end

    // Set is OR-ed after the clear so a pulse beats a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q <= '0;
            ena_q <= '0;
            act_q <= '0;
        end else if (clk_ce) begin
            pri_q <= pri_d;
            ena_q <= ena_d;
            act_q <= (act_q & ~act_clr) | act_set;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < 2; k++) begin
            if (bus_address_in == IRQ_PRI + 24'(k))
                rd_dat = pri_q[8*k +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            if (bus_address_in == IRQ_ENA + 24'(k))
                rd_dat = ena_q[8*k +: 8];
            if (bus_address_in == IRQ_ACT + 24'(k))
                rd_dat = act_q[8*k +: 8];
        end
        // The trigger register is write-only (or absent); it always reads zero.
        if (bus_address_in == IRQ_SWT)
            rd_dat = '0;
    end

    // Data is driven only while the CPU strobes a read; reads have no side effects.
    assign bus_data_out = bus_read ? rd_dat : 8'h00;

    // ---------------- arbitration ----------------
    assign cand = act_q & ena_q;

    irq_priority_encoder u_enc (
        .req_vec    (cand),
        .grp_pri_in (pri_q),
        .valid      (win_vld),
        .index      (win_idx),
        .pri        (win_pri)
    );

    // ---------------- request FSM ----------------
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = REQ;
                    vec_d   = win_idx;
                    prio_d  = win_pri;
                end
            end
            REQ: begin
                if (!win_vld) begin
                    state_d = IDLE;
                end else if (irq_ack) begin
                    // CPU took the vector it saw; keep it frozen for service.
                    state_d = SERVICE;
                end else begin
                    vec_d  = win_idx;
                    prio_d = win_pri;
                end
            end
            SERVICE: begin
                if (!act_q[vec_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            prio_q  <= '0;
            req_q   <= 1'b0;
        end else if (clk_ce) begin
            state_q <= state_d;
            vec_q   <= vec_d;
            prio_q  <= prio_d;
            req_q   <= (state_d == REQ);
        end
    end

    assign irq_req    = req_q;
    assign irq_vector = vec_q;
    assign irq_pri    = prio_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios followed by randomized traffic, all checked against a behavioural model.
// Latency: model advances once per clock edge alongside the design.
// Backpressure: n/a.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_ce;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [31:0] irq_src;
    logic        irq_req;
    logic [4:0]  irq_vector;
    logic [1:0]  irq_pri;
    logic        irq_ack;

    localparam logic [23:0] A_PRI = 24'h2020;
    localparam logic [23:0] A_ENA = 24'h2023;
    localparam logic [23:0] A_ACT = 24'h2027;
    localparam logic [23:0] A_SWT = 24'h202B;

    irq_controller dut (
        .clk            (clk),
        .reset          (reset),
        .clk_ce         (clk_ce),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_src        (irq_src),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .irq_pri        (irq_pri),
        .irq_ack        (irq_ack)
    );

    always #5 clk = ~clk;

    // Reference model: register images plus a "mode" of the CPU request
    // (0 = nothing shown, 1 = request shown, 2 = being serviced).
    logic [15:0] m_pri;
    logic [31:0] m_ena;
    logic [31:0] m_act;
    int          m_mode;
    logic        m_req;
    int          m_vec;
    int          m_prio;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_level(input int n);
        return int'((m_pri >> (2 * (n / 4))) & 16'h3);
    endfunction

    function automatic logic [7:0] m_read(input logic rd, input logic [23:0] a);
        int o;
        if (!rd) return 8'h00;
        o = int'(a) - 32'h2020;
        if (o >= 0 && o < 2)  return m_pri[8*o +: 8];
        if (o >= 3 && o < 7)  return m_ena[8*(o-3) +: 8];
        if (o >= 7 && o < 11) return m_act[8*(o-7) +: 8];
        return 8'h00;
    endfunction

    // One clock edge of the specified behaviour, using the inputs as sampled.
    task automatic m_edge();
        bit          v;
        int          idx;
        int          p;
        int          o;
        logic [31:0] set;
        logic [31:0] clr;
        if (reset) begin
            m_pri = 0; m_ena = 0; m_act = 0;
            m_mode = 0; m_req = 0; m_vec = 0; m_prio = 0;
            return;
        end
        if (!clk_ce) return;
        // Winner: search priority levels from highest down, first index at that level.
        v = 0; idx = 0; p = 0;
        for (int lvl = 3; lvl >= 1; lvl--)
            for (int n = 0; n < 32; n++)
                if (!v && m_act[n] && m_ena[n] && m_level(n) == lvl) begin
                    v = 1; idx = n; p = lvl;
                end
        case (m_mode)
            0: if (v) begin m_mode = 1; m_vec = idx; m_prio = p; end
            1: begin
                if (!v) m_mode = 0;
                else if (irq_ack) m_mode = 2;
                else begin m_vec = idx; m_prio = p; end
            end
            default: if (!m_act[m_vec]) m_mode = 0;
        endcase
        m_req = (m_mode == 1);
        set = irq_src;
        clr = 0;
        if (bus_write) begin
            o = int'(bus_address_in) - 32'h2020;
            if (o >= 0 && o < 2)  m_pri[8*o +: 8] = bus_data_in;
            if (o >= 3 && o < 7)  m_ena[8*(o-3) +: 8] = bus_data_in;
            if (o >= 7 && o < 11) clr[8*(o-7) +: 8] = bus_data_in;
`ifdef IRQ_SWTRIG_EN
            if (o == 11 && bus_data_in[7]) set[bus_data_in[4:0]] = 1'b1;
`endif
        end
        m_act = (m_act & ~clr) | set;
    endtask

    // Check read data, advance one edge, check outputs, drop one-cycle pulses.
    task automatic tick();
        #2;
        chk("rd", {24'h0, bus_data_out}, {24'h0, m_read(bus_read, bus_address_in)});
        @(posedge clk);
        m_edge();
        #1;
        chk("req", {31'h0, irq_req}, {31'h0, m_req});
        chk("vec", {27'h0, irq_vector}, m_vec);
        chk("pri", {30'h0, irq_pri}, m_prio);
        irq_src   = '0;
        bus_write = 1'b0;
        irq_ack   = 1'b0;
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clk_ce = 1'b1; bus_write = 1'b0; bus_read = 1'b1;
        bus_address_in = A_PRI; bus_data_in = '0; irq_src = '0; irq_ack = 1'b0;
        repeat (2) @(posedge clk);
        m_edge();
        #1;
        reset = 1'b0;
        chk("rst_req", {31'h0, irq_req}, 0);
        chk("rst_vec", {27'h0, irq_vector}, 0);
        chk("rst_pri", {30'h0, irq_pri}, 0);
        chk("rst_prireg", {24'h0, bus_data_out}, 0);

        // 1: single source, latency two cycles
        wr(A_ENA, 8'h08);
        wr(A_PRI, 8'h02);
        irq_src = 32'h0000_0008;
        tick();
        chk("t1_early", {31'h0, irq_req}, 0);
        tick();
        chk("t1_req", {31'h0, irq_req}, 1);
        chk("t1_vec", {27'h0, irq_vector}, 3);
        chk("t1_pri", {30'h0, irq_pri}, 2);

        // 2: higher priority wins, falls back after W1C
        do_reset();
        wr(A_ENA, 8'h08);
        wr(A_ENA + 24'd1, 8'h02);
        wr(A_PRI, 8'h31);
        irq_src = (32'h1 << 3) | (32'h1 << 9);
        tick();
        tick();
        chk("t2_vec9", {27'h0, irq_vector}, 9);
        chk("t2_pri3", {30'h0, irq_pri}, 3);
        wr(A_ACT + 24'd1, 8'h02);
        tick();
        chk("t2_req", {31'h0, irq_req}, 1);
        chk("t2_vec3", {27'h0, irq_vector}, 3);
        chk("t2_pri1", {30'h0, irq_pri}, 1);

        // 3: tie goes to lowest index, ack holds off the next one until cleared
        do_reset();
        wr(A_ENA, 8'h30);
        wr(A_PRI, 8'h08);
        irq_src = (32'h1 << 4) | (32'h1 << 5);
        tick();
        tick();
        chk("t3_vec4", {27'h0, irq_vector}, 4);
        irq_ack = 1'b1;
        tick();
        chk("t3_svc", {31'h0, irq_req}, 0);
        tick();
        tick();
        chk("t3_hold", {31'h0, irq_req}, 0);
        wr(A_ACT, 8'h10);
        tick();
        tick();
        chk("t3_req5", {31'h0, irq_req}, 1);
        chk("t3_vec5", {27'h0, irq_vector}, 5);

        // 4: set beats W1C on the same bit
        do_reset();
        irq_src = 32'h1 << 7;
        wr(A_ACT, 8'h80);
        bus_read = 1'b1;
        bus_address_in = A_ACT;
        #1;
        chk("t4_act", {24'h0, bus_data_out}, 32'h80);

        // 5: masked group, unmask, then reset during service
        do_reset();
        wr(A_ENA, 8'h02);
        irq_src = 32'h2;
        tick();
        tick();
        tick();
        chk("t5_masked", {31'h0, irq_req}, 0);
        wr(A_PRI, 8'h01);
        tick();
        chk("t5_req", {31'h0, irq_req}, 1);
        chk("t5_vec", {27'h0, irq_vector}, 1);
        irq_ack = 1'b1;
        tick();
        chk("t5_svc", {31'h0, irq_req}, 0);
        do_reset();
        chk("t5_rst_req", {31'h0, irq_req}, 0);
        chk("t5_rst_vec", {27'h0, irq_vector}, 0);
        chk("t5_rst_pri", {30'h0, irq_pri}, 0);
        bus_read = 1'b1;
        bus_address_in = A_ACT;
        #1;
        chk("t5_rst_act", {24'h0, bus_data_out}, 0);

        // 6: software trigger
        do_reset();
        wr(A_ENA + 24'd1, 8'h10);
        wr(A_PRI, 8'hC0);
        wr(A_SWT, 8'h8C);
        tick();
`ifdef IRQ_SWTRIG_EN
        chk("t6_req", {31'h0, irq_req}, 1);
        chk("t6_vec", {27'h0, irq_vector}, 12);
`else
        chk("t6_req", {31'h0, irq_req}, 0);
        bus_read = 1'b1;
        bus_address_in = A_ACT + 24'd1;
        #1;
        chk("t6_act", {24'h0, bus_data_out}, 0);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            clk_ce = ($urandom_range(0, 7) != 0);
            irq_src = ($urandom_range(0, 1) == 0) ? '0 : ($urandom & $urandom & $urandom & $urandom);
            bus_address_in = 24'h201F + 24'($urandom_range(0, 14));
            bus_data_in = 8'($urandom);
            bus_write = ($urandom_range(0, 2) == 0);
            bus_read = 1'($urandom_range(0, 1));
            irq_ack = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
